// File: rtl/card_pkg.sv
// Shared types and constants for the card dealer: deck geometry, FSM states,
// and the LFSR step function used by the shuffle engine.
package card_pkg;

  localparam int          DECK_SIZE = 52;
  localparam int          RANKS     = 13;
  localparam int          CARD_W    = 4;
  localparam int          IDX_W     = 6;
  localparam logic [15:0] LFSR_MASK = 16'hB400;

  localparam logic [CARD_W-1:0] CARD_NONE  = '0;
  localparam logic [IDX_W-1:0]  DECK_COUNT = IDX_W'(DECK_SIZE);
  localparam logic [IDX_W-1:0]  DECK_LAST  = IDX_W'(DECK_SIZE - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SHUF = 2'd1,
    DEAL = 2'd2
  } state_e;

  // Ordered deck: positions cycle through ranks 1..13.
  function automatic logic [CARD_W-1:0] init_card(input int i);
    return CARD_W'((i % RANKS) + 1);
  endfunction

  // Galois right shift; the mask is applied when the shifted-out bit is 1.
  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return (s >> 1) ^ (s[0] ? LFSR_MASK : 16'h0000);
  endfunction

endpackage

// File: rtl/card_lfsr16.sv
// 16-bit Galois LFSR that advances only when step is high; loads SEED on reset.
module card_lfsr16
  import card_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        step,
  output logic [15:0] state
);

  logic [15:0] r_lfsr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_lfsr <= SEED;
    end else if (step) begin
      r_lfsr <= lfsr_next(r_lfsr);
    end
  end

  assign state = r_lfsr;

endmodule

// File: rtl/card_dealer.sv
// 52-card dealer: ordered deck at reset, LFSR-driven swap shuffle (one swap per
// cycle), and single-cycle dealing with a registered valid strobe.
module card_dealer
  import card_pkg::*;
#(
  parameter logic [15:0] SEED             = 16'hACE1,
  parameter bit          SHUFFLE_ON_RESET = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pip,
  input  logic              shuffle,
  output logic [CARD_W-1:0] number,
  output logic              valid,
  output logic              busy,
  output logic              empty,
  output logic [IDX_W-1:0]  cards_left
);

  state_e             r_state;
  logic [CARD_W-1:0]  r_deck [DECK_SIZE];
  logic [IDX_W-1:0]   r_ptr;
  logic [IDX_W-1:0]   r_idx;
  logic [IDX_W-1:0]   r_cards_left;
  logic [CARD_W-1:0]  r_number;
  logic               r_valid;
  logic               r_busy;
  logic               r_empty;
  logic               r_pending;

  logic [15:0]        w_lfsr;
  logic [IDX_W-1:0]   w_raw;
  logic [IDX_W-1:0]   w_swap;

  card_lfsr16 #(.SEED(SEED)) u_lfsr (
    .clk   (clk),
    .rst   (rst),
    .step  (r_state == SHUF),
    .state (w_lfsr)
  );

  // Fold 52..63 back into the deck range.
  assign w_raw  = w_lfsr[IDX_W-1:0];
  assign w_swap = (w_raw >= DECK_COUNT) ? (w_raw - DECK_COUNT) : w_raw;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: the deck array is reset on purpose: reset must restore the
      // ordered deck and discard any partial permutation.
      for (int i = 0; i < DECK_SIZE; i++) begin
        r_deck[i] <= init_card(i);
      end
      r_state      <= SHUFFLE_ON_RESET ? SHUF : IDLE;
      r_busy       <= SHUFFLE_ON_RESET;
      r_ptr        <= '0;
      r_idx        <= '0;
      r_cards_left <= DECK_COUNT;
      r_number     <= CARD_NONE;
      r_valid      <= 1'b0;
      r_empty      <= 1'b0;
      r_pending    <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (shuffle) begin
            r_state <= SHUF;
            r_idx   <= '0;
            r_busy  <= 1'b1;
          end else if (pip) begin
            r_state <= DEAL;
          end
        end

        SHUF: begin
          // NOTE: both writes sample the pre-edge deck, so this is a true swap
          // and idx == r degenerates to rewriting the same value.
          r_deck[r_idx]  <= r_deck[w_swap];
          r_deck[w_swap] <= r_deck[r_idx];
          if (pip) begin
            r_pending <= 1'b1;
          end
          if (r_idx == DECK_LAST) begin
            r_ptr        <= '0;
            r_cards_left <= DECK_COUNT;
            r_empty      <= 1'b0;
            r_busy       <= 1'b0;
            r_pending    <= 1'b0;
            r_state      <= (r_pending || pip) ? DEAL : IDLE;
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end

        DEAL: begin
          r_valid <= 1'b1;
          r_state <= IDLE;
          if (r_ptr != DECK_COUNT) begin
            r_number     <= r_deck[r_ptr];
            r_ptr        <= r_ptr + 1'b1;
            r_cards_left <= r_cards_left - 1'b1;
            r_empty      <= (r_ptr == DECK_LAST);
          end else begin
            r_number <= CARD_NONE;
          end
        end

        default: r_state <= IDLE;
      endcase
    end
  end

  assign number     = r_number;
  assign valid      = r_valid;
  assign busy       = r_busy;
  assign empty      = r_empty;
  assign cards_left = r_cards_left;

endmodule

// File: tb/tb_card_dealer.sv
// Self-checking bench: one dealer without reset shuffle (u0) and one with (u1),
// checked against an array-based deck model.
module tb_card_dealer;

  logic       clk = 1'b0;
  logic       rst0, pip0, shf0, rst1, pip1, shf1;
  logic [3:0] num0, num1;
  logic       val0, val1, busy0, busy1, emp0, emp1;
  logic [5:0] left0, left1;

  int n_checks = 0;
  int n_fail   = 0;

  // Deck model for u1.
  int          mdeck [52];
  int          mptr;
  logic [15:0] mlfsr;
  int          hist  [14];

  typedef struct {
    int gap;
    int exp_num;
    int exp_left;
    int exp_empty;
  } vec_t;
  vec_t vecs [13];

  always #5 clk = ~clk;

  card_dealer #(.SEED(16'hACE1), .SHUFFLE_ON_RESET(1'b0)) u0 (
    .clk(clk), .rst(rst0), .pip(pip0), .shuffle(shf0),
    .number(num0), .valid(val0), .busy(busy0), .empty(emp0), .cards_left(left0)
  );

  card_dealer #(.SEED(16'hACE1), .SHUFFLE_ON_RESET(1'b1)) u1 (
    .clk(clk), .rst(rst1), .pip(pip1), .shuffle(shf1),
    .number(num1), .valid(val1), .busy(busy1), .empty(emp1), .cards_left(left1)
  );

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic step_clk();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] model_lfsr_step(input logic [15:0] l);
    return (l >> 1) ^ ((l & 16'h1) != 0 ? 16'hB400 : 16'h0000);
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 52; i++) mdeck[i] = (i % 13) + 1;
    mptr  = 0;
    mlfsr = 16'hACE1;
  endfunction

  function automatic void model_shuffle();
    int r, t;
    for (int idx = 0; idx < 52; idx++) begin
      r = int'(mlfsr % 64);
      if (r >= 52) r = r - 52;
      t          = mdeck[idx];
      mdeck[idx] = mdeck[r];
      mdeck[r]   = t;
      mlfsr      = model_lfsr_step(mlfsr);
    end
    mptr = 0;
  endfunction

  function automatic int model_deal();
    int v;
    if (mptr < 52) begin
      v = mdeck[mptr];
      mptr++;
      return v;
    end
    return 0;
  endfunction

  // Pulse pip on u1, then check the dealt card against the model.
  task automatic deal_check_u1(input string tag);
    int exp;
    exp  = model_deal();
    pip1 = 1'b1;
    step_clk();
    pip1 = 1'b0;
    check({tag, " valid_latency"}, val1, 0);
    step_clk();
    check({tag, " valid"}, val1, 1);
    check({tag, " number"}, num1, exp);
    check({tag, " cards_left"}, left1, 52 - mptr);
    check({tag, " empty"}, emp1, (mptr == 52) ? 1 : 0);
    if (exp >= 1 && exp <= 13) hist[exp]++;
  endtask

  // Step until u1 busy falls (bounded); returns busy cycles and valids seen.
  task automatic wait_busy_u1(output int cycles, output int valids);
    cycles = 0;
    valids = 0;
    while (busy1 && cycles < 200) begin
      step_clk();
      cycles++;
      if (val1) valids++;
    end
  endtask

  initial begin
    int cyc, nval, off, do_pip, exp, op;

    rst0 = 1'b1; pip0 = 1'b0; shf0 = 1'b0;
    rst1 = 1'b1; pip1 = 1'b0; shf1 = 1'b0;
    model_reset();
    for (int i = 0; i < 14; i++) hist[i] = 0;
    for (int i = 0; i < 13; i++) begin
      vecs[i].gap       = 2;
      vecs[i].exp_num   = i + 1;
      vecs[i].exp_left  = 51 - i;
      vecs[i].exp_empty = 0;
    end

    step_clk();
    step_clk();
    check("rst u0 busy", busy0, 0);
    check("rst u1 busy", busy1, 1);
    check("rst u0 number", num0, 0);
    check("rst u0 valid", val0, 0);
    check("rst u0 empty", emp0, 0);
    check("rst u0 cards_left", left0, 52);
    check("rst u1 cards_left", left1, 52);
    rst0 = 1'b0;
    rst1 = 1'b0;

    // Reset-time shuffle on u1: busy exactly 52 cycles.
    model_shuffle();
    wait_busy_u1(cyc, nval);
    check("u1 reset shuffle busy cycles", cyc, 52);
    check("u1 reset shuffle valids", nval, 0);

    // u0: ordered deck, 13 pips spaced 4 cycles.
    for (int i = 0; i < 13; i++) begin
      pip0 = 1'b1;
      step_clk();
      pip0 = 1'b0;
      check($sformatf("ordered[%0d] valid_latency", i), val0, 0);
      step_clk();
      check($sformatf("ordered[%0d] valid", i), val0, 1);
      check($sformatf("ordered[%0d] number", i), num0, vecs[i].exp_num);
      check($sformatf("ordered[%0d] cards_left", i), left0, vecs[i].exp_left);
      check($sformatf("ordered[%0d] empty", i), emp0, vecs[i].exp_empty);
      for (int g = 0; g < vecs[i].gap; g++) begin
        step_clk();
        check($sformatf("ordered[%0d] strobe_low", i), val0, 0);
        check($sformatf("ordered[%0d] number_hold", i), num0, vecs[i].exp_num);
      end
    end

    // u1: deal all 52 of the shuffled deck.
    for (int i = 0; i < 52; i++) deal_check_u1($sformatf("deal[%0d]", i));
    for (int v = 1; v <= 13; v++) check($sformatf("hist value %0d", v), hist[v], 4);
    check("after 52 empty", emp1, 1);
    check("after 52 cards_left", left1, 0);

    deal_check_u1("deal[52] past empty");
    check("past empty number", num1, 0);
    check("past empty stays empty", emp1, 1);

    // Reshuffle from empty.
    shf1 = 1'b1;
    step_clk();
    shf1 = 1'b0;
    model_shuffle();
    check("reshuffle busy rises", busy1, 1);
    wait_busy_u1(cyc, nval);
    check("reshuffle busy cycles", cyc, 52);
    check("reshuffle empty", emp1, 0);
    check("reshuffle cards_left", left1, 52);

    // pip 10 cycles into a shuffle pass is held until the pass ends.
    shf1 = 1'b1;
    step_clk();
    shf1 = 1'b0;
    model_shuffle();
    repeat (9) step_clk();
    pip1 = 1'b1;
    step_clk();
    pip1 = 1'b0;
    wait_busy_u1(cyc, nval);
    check("pending pip busy cycles", cyc, 42);
    check("pending pip valid during busy", nval, 0);
    check("pending pip valid at busy fall", val1, 0);
    exp = model_deal();
    step_clk();
    check("pending pip valid after", val1, 1);
    check("pending pip number", num1, exp);
    check("pending pip cards_left", left1, 51);

    // pip and shuffle together: shuffle wins, pip dropped.
    pip1 = 1'b1;
    shf1 = 1'b1;
    step_clk();
    pip1 = 1'b0;
    shf1 = 1'b0;
    model_shuffle();
    wait_busy_u1(cyc, nval);
    check("pip+shuffle busy cycles", cyc, 52);
    check("pip+shuffle valids", nval, 0);
    step_clk();
    check("pip+shuffle dropped pip", val1, 0);
    check("pip+shuffle ptr rewound", left1, 52);
    deal_check_u1("pip+shuffle first card");

    // Randomized traffic against the model.
    for (int k = 0; k < 60; k++) begin
      op = $urandom_range(0, 9);
      repeat ($urandom_range(0, 3)) step_clk();
      if (op == 0) begin
        do_pip = $urandom_range(0, 1);
        off    = $urandom_range(0, 40);
        shf1 = 1'b1;
        step_clk();
        shf1 = 1'b0;
        model_shuffle();
        cyc  = 0;
        nval = 0;
        while (busy1 && cyc < 200) begin
          if (do_pip != 0 && cyc == off) pip1 = 1'b1;
          step_clk();
          pip1 = 1'b0;
          cyc++;
          if (val1) nval++;
        end
        check($sformatf("rand[%0d] shuffle busy cycles", k), cyc, 52);
        check($sformatf("rand[%0d] shuffle valids", k), nval, 0);
        step_clk();
        if (do_pip != 0) begin
          exp = model_deal();
          check($sformatf("rand[%0d] pending valid", k), val1, 1);
          check($sformatf("rand[%0d] pending number", k), num1, exp);
        end else begin
          check($sformatf("rand[%0d] idle valid", k), val1, 0);
        end
        check($sformatf("rand[%0d] cards_left", k), left1, 52 - mptr);
      end else begin
        deal_check_u1($sformatf("rand[%0d]", k));
      end
    end

    // u0: reset 20 cycles into a shuffle discards the partial permutation.
    shf0 = 1'b1;
    step_clk();
    shf0 = 1'b0;
    repeat (20) step_clk();
    check("midshuffle busy before rst", busy0, 1);
    rst0 = 1'b1;
    #1;
    check("midshuffle rst busy", busy0, 0);
    check("midshuffle rst valid", val0, 0);
    check("midshuffle rst number", num0, 0);
    check("midshuffle rst empty", emp0, 0);
    check("midshuffle rst cards_left", left0, 52);
    step_clk();
    rst0 = 1'b0;
    step_clk();
    pip0 = 1'b1;
    step_clk();
    pip0 = 1'b0;
    step_clk();
    check("after rst valid", val0, 1);
    check("after rst number", num0, 1);
    check("after rst cards_left", left0, 51);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
